cntr_seq_ctrl: RTL and testbench
================================

Name: cntr_seq_ctrl

Overview:
Sequencer that drives the enable and clear inputs of the downstream saturating event counter and consumes its terminal-count flag. On start it clears the counter, then issues one enable pulse every PRESCALE clocks until the counter reports done. It repeats this for REPEAT passes, then reports completion. Abort and snapshot support cover timeout and watchdog use.

Parameters:
PRESCALE, 50, clocks per counter enable pulse; legal range 1..65535.
REPEAT, 4, number of terminal-count passes per run; 0 = continuous until abort.
CNT_W, 10, width of counter value input; matches counter MAX_COUNT 1000.
RUN_W, 8, width of pass counter; REPEAT must be <= 2^RUN_W-1.

Ports:
iClk  input  1  clock; all logic on posedge.
iRst  input  1  synchronous reset, active-high.
iStart  input  1  start request, sampled in IDLE only.
iAbort  input  1  abort request, sampled in CLEAR/RUN.
iCntDone  input  1  terminal-count flag from counter.
iCntr  input  CNT_W  counter value.
oCntEn  output  1  counter enable; single-cycle pulses.
oCntRst_n  output  1  counter synchronous clear, active-low.
oBusy  output  1  high in CLEAR, RUN, FINISH.
oDone  output  1  one-cycle pulse on normal completion.
oRunCnt  output  RUN_W  passes completed in current/last run.
oAbortVal  output  CNT_W  iCntr captured when abort taken.

Behaviour:
- All outputs registered. Reset values: oCntEn=0, oCntRst_n=1, oBusy=0, oDone=0, oRunCnt=0, oAbortVal=0. State=IDLE. Prescaler pCnt=0.
- IDLE: oCntEn=0, oCntRst_n=1, oBusy=0.
  - iStart=1 and iAbort=0 -> CLEAR; oRunCnt<=0.
  - iStart and iAbort together in IDLE: stay IDLE. Abort wins.
- CLEAR (1 cycle): oCntRst_n=0, oBusy=1, pCnt<=0. Next state RUN, unless iAbort -> IDLE.
- RUN: pCnt increments each cycle and wraps PRESCALE-1 -> 0.
  - oCntEn<=1 for the cycle after pCnt==PRESCALE-1, only if iCntDone=0 and iAbort=0. Otherwise oCntEn<=0.
  - Result: the first enable occurs PRESCALE+1 cycles after CLEAR. Enables are then spaced exactly PRESCALE cycles apart.
  - PRESCALE=1: oCntEn high every RUN cycle while iCntDone=0.
  - iCntDone sampled high: oRunCnt<=oRunCnt+1, oCntEn<=0. If REPEAT!=0 and oRunCnt+1==REPEAT -> FINISH, else -> CLEAR (next pass).
  - REPEAT=0: passes repeat forever. oRunCnt wraps modulo 2^RUN_W.
  - iCntDone high on first RUN cycle (counter MAX 0) counts as a pass with zero enables.
- FINISH (1 cycle): oDone=1, oBusy=1. Next IDLE. oRunCnt holds its value until the next start.
- Abort in CLEAR or RUN (priority over iCntDone in the same cycle):
  - oAbortVal<=iCntr, state -> IDLE, oCntEn=0 from next cycle.
  - No oDone pulse. oRunCnt holds. Counter value is left untouched and cleared by the next start.
- iStart outside IDLE: ignored, no queueing.
- iRst at any time: returns to reset values next cycle. Any in-flight pass is discarded.
- The block never asserts oCntEn and oCntRst_n=0 in the same cycle.

Test Plan:
1. PRESCALE=4, REPEAT=2, counter MAX=3; pulse iStart -> 2 CLEAR cycles seen (oCntRst_n low). Exactly 3 oCntEn pulses per pass, 4 cycles apart, first one 5 cycles after CLEAR. Exactly one oDone pulse, oRunCnt=2, oBusy low after FINISH.
2. Same config; assert iAbort after the 2nd enable of pass 1 (iCntr=2) -> IDLE next cycle, oAbortVal=2, oRunCnt=0, no oDone, no further oCntEn.
3. iStart and iAbort together in IDLE -> stays IDLE, oBusy=0. iStart pulsed during RUN -> no effect on enable count or timing.
4. REPEAT=0, PRESCALE=1, MAX=3 -> continuous passes, oRunCnt increments 1,2,3... and wraps 255 -> 0 with RUN_W=8. oDone never pulses. Abort terminates the run.
5. iRst asserted mid-RUN (pCnt=2) -> next cycle all outputs at reset values. A subsequent iStart restarts cleanly with full timing as in scenario 1.
6. iCntDone and iAbort high in the same RUN cycle -> abort taken, oRunCnt unchanged, oAbortVal=iCntr (3).

Source files
------------

// File: rtl/cntr_seq_ctrl_if.sv
// rtl/cntr_seq_ctrl_if.sv - control and counter-side signal bundle for cntr_seq_ctrl
interface cntr_seq_ctrl_if #(
    parameter int CNT_W = 10,
    parameter int RUN_W = 8
);
    // Requests from the host and status from the event counter
    logic             iStart;
    logic             iAbort;
    logic             iCntDone;
    logic [CNT_W-1:0] iCntr;

    // Counter drive and status back to the host
    logic             oCntEn;
    logic             oCntRst_n;
    logic             oBusy;
    logic             oDone;
    logic [RUN_W-1:0] oRunCnt;
    logic [CNT_W-1:0] oAbortVal;

    // Environment side: host plus counter
    modport master (
        output iStart, iAbort, iCntDone, iCntr,
        input  oCntEn, oCntRst_n, oBusy, oDone, oRunCnt, oAbortVal
    );

    // Sequencer side
    modport slave (
        input  iStart, iAbort, iCntDone, iCntr,
        output oCntEn, oCntRst_n, oBusy, oDone, oRunCnt, oAbortVal
    );
endinterface

// File: rtl/cntr_seq_ctrl.sv
// rtl/cntr_seq_ctrl.sv - pass sequencer driving a saturating event counter
module cntr_seq_ctrl #(
    parameter int PRESCALE = 50,
    parameter int REPEAT   = 4,
    parameter int CNT_W    = 10,
    parameter int RUN_W    = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    cntr_seq_ctrl_if.slave   bus
);

    // Prescaler is sized for the full legal PRESCALE range
    localparam int          PCNT_W = 16;
    localparam logic [PCNT_W-1:0] PMAX   = PCNT_W'(PRESCALE - 1);
    localparam logic [RUN_W-1:0]  RUNLIM = RUN_W'(REPEAT);
    localparam bit          CONTINUOUS = (REPEAT == 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state;
    state_t nextState;

    // Registered outputs and datapath
    logic              cntEn;
    logic              cntRst_n;
    logic              busy;
    logic              done;
    logic [RUN_W-1:0]  runCnt;
    logic [CNT_W-1:0]  abortVal;
    logic [PCNT_W-1:0] pCnt;

    // Next values computed from the current state and inputs
    logic              cntEnNxt;
    logic              cntRstNxt_n;
    logic              busyNxt;
    logic              doneNxt;
    logic [RUN_W-1:0]  runCntNxt;
    logic [CNT_W-1:0]  abortValNxt;
    logic [PCNT_W-1:0] pCntNxt;

    logic              prescaleHit;
    logic [RUN_W-1:0]  runInc;
    logic              lastPass;
    logic              activeState;

    assign prescaleHit = (pCnt == PMAX);
    assign runInc      = runCnt + RUN_W'(1);
    assign lastPass    = !CONTINUOUS && (runInc == RUNLIM);
    assign activeState = (state == CLEAR) || (state == RUN);

    // State register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; abort outranks start and terminal count
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.iStart && !bus.iAbort) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                nextState = bus.iAbort ? IDLE : RUN;
            end
            RUN: begin
                if (bus.iAbort) begin
                    nextState = IDLE;
                end else if (bus.iCntDone) begin
                    nextState = lastPass ? FINISH : CLEAR;
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Output and datapath next values, decoded from the state being entered
    always_comb begin
        cntEnNxt    = 1'b0;
        cntRstNxt_n = (nextState != CLEAR);
        busyNxt     = (nextState != IDLE);
        doneNxt     = (nextState == FINISH);
        runCntNxt   = runCnt;
        abortValNxt = abortVal;
        pCntNxt     = '0;

        if (state == RUN) begin
            pCntNxt = prescaleHit ? '0 : pCnt + PCNT_W'(1);
            // Staying in RUN already implies no abort and no terminal count
            cntEnNxt = prescaleHit && (nextState == RUN);
        end

        if ((state == IDLE) && (nextState == CLEAR)) begin
            runCntNxt = '0;
        end else if ((state == RUN) && !bus.iAbort && bus.iCntDone) begin
            runCntNxt = runInc;
        end

        if (activeState && bus.iAbort) begin
            abortValNxt = bus.iCntr;
        end
    end

    // Output registers; counter clear idles high so the counter runs freely
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cntEn    <= 1'b0;
            cntRst_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            runCnt   <= '0;
            abortVal <= '0;
            pCnt     <= '0;
        end else begin
            cntEn    <= cntEnNxt;
            cntRst_n <= cntRstNxt_n;
            busy     <= busyNxt;
            done     <= doneNxt;
            runCnt   <= runCntNxt;
            abortVal <= abortValNxt;
            pCnt     <= pCntNxt;
        end
    end

    assign bus.oCntEn    = cntEn;
    assign bus.oCntRst_n = cntRst_n;
    assign bus.oBusy     = busy;
    assign bus.oDone     = done;
    assign bus.oRunCnt   = runCnt;
    assign bus.oAbortVal = abortVal;

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// tb/tb_cntr_seq_ctrl.sv - scoreboard bench for cntr_seq_ctrl with saturating counter models
module tb_cntr_seq_ctrl;

    localparam int CNT_W = 10;
    localparam int RUN_W = 8;
    localparam int MAXA  = 3;
    localparam int MAXB  = 3;

    localparam int KCLR  = 0;
    localparam int KEN   = 1;
    localparam int KDONE = 2;

    logic iClk = 1'b0;
    logic rstA;
    logic rstB;

    always #5 iClk = ~iClk;

    cntr_seq_ctrl_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) busA ();
    cntr_seq_ctrl_if #(.CNT_W(CNT_W), .RUN_W(RUN_W)) busB ();

    cntr_seq_ctrl #(.PRESCALE(4), .REPEAT(2), .CNT_W(CNT_W), .RUN_W(RUN_W)) dutA (
        .iClk (iClk),
        .iRst (rstA),
        .bus  (busA)
    );

    cntr_seq_ctrl #(.PRESCALE(1), .REPEAT(0), .CNT_W(CNT_W), .RUN_W(RUN_W)) dutB (
        .iClk (iClk),
        .iRst (rstB),
        .bus  (busB)
    );

    // Saturating event counter models
    logic [CNT_W-1:0] cntA;
    logic [CNT_W-1:0] cntB;

    always @(posedge iClk) begin
        if (rstA || !busA.oCntRst_n) cntA <= '0;
        else if (busA.oCntEn && (cntA < CNT_W'(MAXA))) cntA <= cntA + 1'b1;
    end

    always @(posedge iClk) begin
        if (rstB || !busB.oCntRst_n) cntB <= '0;
        else if (busB.oCntEn && (cntB < CNT_W'(MAXB))) cntB <= cntB + 1'b1;
    end

    assign busA.iCntr    = cntA;
    assign busA.iCntDone = (cntA == CNT_W'(MAXA));
    assign busB.iCntr    = cntB;
    assign busB.iCntDone = (cntB == CNT_W'(MAXB));

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t qA[$];
    ev_t qB[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic evMatch(input string name, input ev_t e, input int kind, input int c, input int v);
        checks++;
        if (e.kind != kind || e.cyc != c || (e.val >= 0 && e.val != v)) begin
            errors++;
            $display("FAIL %s: got kind=%0d cyc=%0d val=%0d expected kind=%0d cyc=%0d val=%0d",
                     name, kind, c, v, e.kind, e.cyc, e.val);
        end
    endtask

    task automatic evUnexpected(input string name, input int kind, input int c);
        checks++;
        errors++;
        $display("FAIL %s: got event kind=%0d at cyc=%0d expected none", name, kind, c);
    endtask

    task automatic pushA(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = v;
        qA.push_back(e);
    endtask

    task automatic pushB(input int kind, input int c, input int v);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = v;
        qB.push_back(e);
    endtask

    // Expected events of a full two-pass run on dutA whose first CLEAR is cycle c
    task automatic pushRunA(input int c);
        pushA(KCLR, c, 0);
        pushA(KEN, c + 5, -1);
        pushA(KEN, c + 9, -1);
        pushA(KEN, c + 13, -1);
        pushA(KCLR, c + 15, 1);
        pushA(KEN, c + 20, -1);
        pushA(KEN, c + 24, -1);
        pushA(KEN, c + 28, -1);
        pushA(KDONE, c + 30, 2);
    endtask

    task automatic toCycle(input int target);
        while (cyc < target) begin
            @(posedge iClk);
            #1;
        end
    endtask

    // Monitor for dutA: every clear, enable and done cycle is matched against the queue
    always @(negedge iClk) begin
        if (!busA.oCntRst_n) begin
            if (qA.size() == 0) evUnexpected("A clear", KCLR, cyc);
            else evMatch("A clear", qA.pop_front(), KCLR, cyc, int'(busA.oRunCnt));
        end
        if (busA.oCntEn) begin
            if (qA.size() == 0) evUnexpected("A enable", KEN, cyc);
            else evMatch("A enable", qA.pop_front(), KEN, cyc, -1);
        end
        if (busA.oDone) begin
            if (qA.size() == 0) evUnexpected("A done", KDONE, cyc);
            else evMatch("A done", qA.pop_front(), KDONE, cyc, int'(busA.oRunCnt));
        end
    end

    // Monitor for dutB
    always @(negedge iClk) begin
        if (!busB.oCntRst_n) begin
            if (qB.size() == 0) evUnexpected("B clear", KCLR, cyc);
            else evMatch("B clear", qB.pop_front(), KCLR, cyc, int'(busB.oRunCnt));
        end
        if (busB.oCntEn) begin
            if (qB.size() == 0) evUnexpected("B enable", KEN, cyc);
            else evMatch("B enable", qB.pop_front(), KEN, cyc, -1);
        end
        if (busB.oDone) begin
            if (qB.size() == 0) evUnexpected("B done", KDONE, cyc);
            else evMatch("B done", qB.pop_front(), KDONE, cyc, int'(busB.oRunCnt));
        end
    end

    initial begin
        int t;
        int c;
        rstA = 1'b1;
        rstB = 1'b1;
        busA.iStart = 1'b0;
        busA.iAbort = 1'b0;
        busB.iStart = 1'b0;
        busB.iAbort = 1'b0;
        @(posedge iClk); #1;
        @(posedge iClk); #1;

        // Reset values
        chk("rst A cntEn", busA.oCntEn, 0);
        chk("rst A cntRst_n", busA.oCntRst_n, 1);
        chk("rst A busy", busA.oBusy, 0);
        chk("rst A done", busA.oDone, 0);
        chk("rst A runCnt", busA.oRunCnt, 0);
        chk("rst A abortVal", busA.oAbortVal, 0);
        chk("rst B cntEn", busB.oCntEn, 0);
        chk("rst B cntRst_n", busB.oCntRst_n, 1);
        chk("rst B busy", busB.oBusy, 0);
        chk("rst B runCnt", busB.oRunCnt, 0);
        rstA = 1'b0;
        rstB = 1'b0;
        toCycle(cyc + 2);

        // Two full passes, three enables each
        t = cyc; c = t + 1;
        pushRunA(c);
        busA.iStart = 1'b1;
        toCycle(c);
        busA.iStart = 1'b0;
        chk("s1 busy in clear", busA.oBusy, 1);
        toCycle(c + 31);
        chk("s1 busy after finish", busA.oBusy, 0);
        chk("s1 runCnt", busA.oRunCnt, 2);
        toCycle(cyc + 3);

        // Abort after the second enable of the first pass
        t = cyc; c = t + 1;
        pushA(KCLR, c, 0);
        pushA(KEN, c + 5, -1);
        pushA(KEN, c + 9, -1);
        busA.iStart = 1'b1;
        toCycle(c);
        busA.iStart = 1'b0;
        toCycle(c + 10);
        busA.iAbort = 1'b1;
        toCycle(c + 11);
        busA.iAbort = 1'b0;
        chk("s2 busy", busA.oBusy, 0);
        chk("s2 abortVal", busA.oAbortVal, 2);
        chk("s2 runCnt", busA.oRunCnt, 0);
        toCycle(c + 25);

        // Start with abort in IDLE is refused; start during RUN is ignored
        busA.iStart = 1'b1;
        busA.iAbort = 1'b1;
        toCycle(cyc + 1);
        busA.iStart = 1'b0;
        busA.iAbort = 1'b0;
        chk("s3 busy after start+abort", busA.oBusy, 0);
        toCycle(cyc + 2);
        t = cyc; c = t + 1;
        pushRunA(c);
        busA.iStart = 1'b1;
        toCycle(c);
        busA.iStart = 1'b0;
        toCycle(c + 7);
        busA.iStart = 1'b1;
        toCycle(c + 8);
        busA.iStart = 1'b0;
        toCycle(c + 31);
        chk("s3 busy after finish", busA.oBusy, 0);
        chk("s3 runCnt", busA.oRunCnt, 2);
        toCycle(cyc + 2);

        // Reset while the prescaler is at 2, then a clean restart
        t = cyc; c = t + 1;
        pushA(KCLR, c, 0);
        busA.iStart = 1'b1;
        toCycle(c);
        busA.iStart = 1'b0;
        toCycle(c + 3);
        rstA = 1'b1;
        toCycle(c + 4);
        rstA = 1'b0;
        chk("s5 cntEn", busA.oCntEn, 0);
        chk("s5 cntRst_n", busA.oCntRst_n, 1);
        chk("s5 busy", busA.oBusy, 0);
        chk("s5 done", busA.oDone, 0);
        chk("s5 runCnt", busA.oRunCnt, 0);
        chk("s5 abortVal", busA.oAbortVal, 0);
        toCycle(cyc + 2);
        t = cyc; c = t + 1;
        pushRunA(c);
        busA.iStart = 1'b1;
        toCycle(c);
        busA.iStart = 1'b0;
        toCycle(c + 31);
        chk("s5 runCnt after restart", busA.oRunCnt, 2);
        toCycle(cyc + 2);

        // Abort coinciding with terminal count on the second pass
        t = cyc; c = t + 1;
        pushA(KCLR, c, 0);
        pushA(KEN, c + 5, -1);
        pushA(KEN, c + 9, -1);
        pushA(KEN, c + 13, -1);
        pushA(KCLR, c + 15, 1);
        pushA(KEN, c + 20, -1);
        pushA(KEN, c + 24, -1);
        pushA(KEN, c + 28, -1);
        busA.iStart = 1'b1;
        toCycle(c);
        busA.iStart = 1'b0;
        toCycle(c + 29);
        busA.iAbort = 1'b1;
        toCycle(c + 30);
        busA.iAbort = 1'b0;
        chk("s6 busy", busA.oBusy, 0);
        chk("s6 runCnt", busA.oRunCnt, 1);
        chk("s6 abortVal", busA.oAbortVal, 3);
        toCycle(c + 40);

        // Continuous passes with PRESCALE=1; pass count wraps through 255 -> 0
        t = cyc; c = t + 1;
        for (int k = 0; k <= 256; k++) begin
            pushB(KCLR, c + 6 * k, k % 256);
            for (int j = 2; j <= 5; j++) pushB(KEN, c + 6 * k + j, -1);
        end
        pushB(KCLR, c + 6 * 257, 1);
        pushB(KEN, c + 6 * 257 + 2, -1);
        pushB(KEN, c + 6 * 257 + 3, -1);
        busB.iStart = 1'b1;
        toCycle(c);
        busB.iStart = 1'b0;
        toCycle(c + 6 * 257 + 3);
        busB.iAbort = 1'b1;
        toCycle(c + 6 * 257 + 4);
        busB.iAbort = 1'b0;
        chk("s4 busy", busB.oBusy, 0);
        chk("s4 abortVal", busB.oAbortVal, 1);
        chk("s4 runCnt", busB.oRunCnt, 1);
        toCycle(cyc + 10);

        chk("A events outstanding", qA.size(), 0);
        chk("B events outstanding", qB.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
